// File: rtl/io_pkg.sv
// Shared definitions for the UAZ peripheral I/O stages: selector codes,
// input-reader state encoding and the handshake timer helper.
package io_pkg;

    localparam logic [2:0] SEL_DIR  = 3'b101;
    localparam logic [2:0] SEL_DATO = 3'b110;
    localparam logic [2:0] SEL_IN   = 3'b111;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_WRITE   = 2'd3
    } in_state_e;

    // Saturating increment so a long-stuck phase never wraps back to zero.
    function automatic logic [TIMER_W-1:0] timer_sat_inc(input logic [TIMER_W-1:0] t);
        logic [TIMER_W-1:0] r;
        if (t == {TIMER_W{1'b1}}) begin
            r = t;
        end else begin
            r = t + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/entradas_puerto_if.sv
// Control-unit / peripheral bus bundle for the input-port reader.
interface entradas_puerto_if;

    logic [2:0] SELEC;
    logic [7:0] RX_DATO;
    logic [2:0] RY;
    logic [7:0] EXT_DATO;
    logic       RD_ACK;
    logic [7:0] DIR_IN;
    logic       RD_REQ;
    logic [2:0] RY_SEL;
    logic [7:0] RY_DATO_IN;
    logic       RY_WE;
    logic       BUSY;
    logic       ERR;

    modport master (
        output SELEC, RX_DATO, RY, EXT_DATO, RD_ACK,
        input  DIR_IN, RD_REQ, RY_SEL, RY_DATO_IN, RY_WE, BUSY, ERR
    );

    modport slave (
        input  SELEC, RX_DATO, RY, EXT_DATO, RD_ACK,
        output DIR_IN, RD_REQ, RY_SEL, RY_DATO_IN, RY_WE, BUSY, ERR
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous peripheral inputs; all flops clear
// on synchronous reset.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift chain: stage 0 takes the raw input, the last stage is the clean output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/entradas_puerto.sv
// Input-port reader: on a rising IN selector code runs a four-phase REQ/ACK
// read from the addressed peripheral and writes the byte to register RY.
module entradas_puerto
    import io_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    entradas_puerto_if.slave  bus
);

    localparam logic [TIMER_W-1:0] TIMEOUT_M1 = TIMER_W'(TIMEOUT - 1);

    in_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               sel_prev_q;
    logic [7:0]         dir_q, dir_d;
    logic [2:0]         ry_sel_q, ry_sel_d;
    logic [7:0]         dato_q, dato_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               ack_s;
    logic               sel_in_s;
    logic               start_s;
    logic               timeout_s;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_ack_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (bus.RD_ACK),
        .q_o (ack_s)
    );

    assign sel_in_s  = (bus.SELEC == SEL_IN);
    assign start_s   = sel_in_s & ~sel_prev_q;
    assign timeout_s = (timer_q >= TIMEOUT_M1);

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_d    = dir_q;
        ry_sel_d = ry_sel_q;
        dato_d   = dato_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    dir_d    = bus.RX_DATO;
                    ry_sel_d = bus.RY;
                    err_d    = 1'b0;
                    timer_d  = 16'd0;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    dato_d  = bus.EXT_DATO;
                    timer_d = 16'd0;
                    state_d = ST_RELEASE;
                end else if (timeout_s) begin
                    dato_d  = 8'hFF;
                    err_d   = 1'b1;
                    timer_d = 16'd0;
                    state_d = ST_RELEASE;
                end else begin
                    timer_d = timer_sat_inc(timer_q);
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_d = ST_WRITE;
                end else if (timeout_s) begin
                    // Peripheral never released ACK: keep the captured byte, flag it.
                    err_d   = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    timer_d = timer_sat_inc(timer_q);
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        we_d   = (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers; the edge detector tracks SELEC even while busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            timer_q    <= 16'd0;
            sel_prev_q <= 1'b0;
            dir_q      <= 8'd0;
            ry_sel_q   <= 3'd0;
            dato_q     <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sel_prev_q <= sel_in_s;
            dir_q      <= dir_d;
            ry_sel_q   <= ry_sel_d;
            dato_q     <= dato_d;
            req_q      <= req_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.DIR_IN     = dir_q;
    assign bus.RD_REQ     = req_q;
    assign bus.RY_SEL     = ry_sel_q;
    assign bus.RY_DATO_IN = dato_q;
    assign bus.RY_WE      = we_q;
    assign bus.BUSY       = busy_q;
    assign bus.ERR        = err_q;

endmodule

// File: tb/tb_entradas_puerto.sv
// Directed bench for entradas_puerto (TIMEOUT=8, SYNC_STAGES=2); cycle k is
// k falling edges after SELEC first reads the IN code.
module tb_entradas_puerto;
    import io_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ack_mode;
    int         total = 0;
    int         bad = 0;
    int         we_cnt = 0;
    int         snap;

    entradas_puerto_if bus();

    entradas_puerto #(
        .TIMEOUT     (8),
        .SYNC_STAGES (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Peripheral model: 0 = ideal (ACK follows REQ), 1 = never acks, 2 = ACK stuck high.
    always_comb begin
        case (ack_mode)
            2'd0:    bus.RD_ACK = bus.RD_REQ;
            2'd1:    bus.RD_ACK = 1'b0;
            default: bus.RD_ACK = 1'b1;
        endcase
    end

    always @(posedge clk) begin
        if (bus.RY_WE === 1'b1) we_cnt = we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_read(input logic [7:0] addr, input logic [2:0] ry, input logic [7:0] ext);
        bus.RX_DATO  = addr;
        bus.RY       = ry;
        bus.EXT_DATO = ext;
        bus.SELEC    = SEL_IN;
    endtask

    // Full ideal-peripheral read checked cycle by cycle against the nominal latency.
    task automatic ideal_read(input string nm, input logic [7:0] addr, input logic [2:0] ry, input logic [7:0] ext);
        snap = we_cnt;
        start_read(addr, ry, ext);
        chk({nm, "_c0_busy"}, 32'(bus.BUSY), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk({nm, "_req"},  32'(bus.RD_REQ), 32'(k <= 3));
            chk({nm, "_busy"}, 32'(bus.BUSY),   32'(k <= 7));
            chk({nm, "_we"},   32'(bus.RY_WE),  32'(k == 7));
            if (k == 1) begin
                chk({nm, "_dir"}, 32'(bus.DIR_IN), 32'(addr));
                bus.SELEC   = 3'b000;
                bus.RX_DATO = 8'h00;
                bus.RY      = 3'd0;
            end
            if (k == 7) begin
                chk({nm, "_sel"},      32'(bus.RY_SEL),     32'(ry));
                chk({nm, "_data"},     32'(bus.RY_DATO_IN), 32'(ext));
                chk({nm, "_err"},      32'(bus.ERR),        32'd0);
                chk({nm, "_dir_held"}, 32'(bus.DIR_IN),     32'(addr));
            end
        end
        chk({nm, "_we_count"}, 32'(we_cnt - snap), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        ack_mode     = 2'd0;
        bus.SELEC    = SEL_IN;
        bus.RX_DATO  = 8'h00;
        bus.RY       = 3'd0;
        bus.EXT_DATO = 8'h00;

        // Reset with IN asserted
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({bus.DIR_IN, bus.RD_REQ, bus.RY_SEL, bus.RY_DATO_IN,
                                bus.RY_WE, bus.BUSY, bus.ERR}), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        bus.SELEC = 3'b000;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(bus.BUSY), 32'd0);
        chk("post_rst_we", 32'(we_cnt), 32'd0);

        // Ideal read
        ideal_read("ideal", 8'h3C, 3'd5, 8'hA7);

        // Timeout in REQ: no ACK ever
        ack_mode = 2'd1;
        snap = we_cnt;
        start_read(8'h55, 3'd2, 8'h11);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("to_req",  32'(bus.RD_REQ), 32'(k <= 8));
            chk("to_busy", 32'(bus.BUSY),   32'(k <= 10));
            chk("to_we",   32'(bus.RY_WE),  32'(k == 10));
            if (k == 1) bus.SELEC = 3'b000;
            if (k == 10) begin
                chk("to_data", 32'(bus.RY_DATO_IN), 32'h0000_00FF);
                chk("to_err",  32'(bus.ERR),        32'd1);
                chk("to_sel",  32'(bus.RY_SEL),     32'd2);
            end
        end
        chk("to_err_sticky", 32'(bus.ERR), 32'd1);
        chk("to_we_count", 32'(we_cnt - snap), 32'd1);
        chk("to_dir", 32'(bus.DIR_IN), 32'h0000_0055);

        // Stuck ACK: times out in RELEASE, keeps captured byte
        ack_mode = 2'd0;
        snap = we_cnt;
        start_read(8'h9A, 3'd7, 8'hC4);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk("stk_req",  32'(bus.RD_REQ), 32'(k <= 3));
            chk("stk_busy", 32'(bus.BUSY),   32'(k <= 12));
            chk("stk_we",   32'(bus.RY_WE),  32'(k == 12));
            if (k == 1) begin
                chk("err_clear_on_start", 32'(bus.ERR), 32'd0);
                bus.SELEC = 3'b000;
            end
            if (k == 3) ack_mode = 2'd2;
            if (k == 4) bus.EXT_DATO = 8'h00;
            if (k == 12) begin
                chk("stk_data", 32'(bus.RY_DATO_IN), 32'h0000_00C4);
                chk("stk_err",  32'(bus.ERR),        32'd1);
                chk("stk_sel",  32'(bus.RY_SEL),     32'd7);
            end
        end
        chk("stk_we_count", 32'(we_cnt - snap), 32'd1);
        ack_mode = 2'd0;
        repeat (4) @(negedge clk);

        // Held IN code: one transaction only
        snap = we_cnt;
        start_read(8'h01, 3'd1, 8'h5E);
        repeat (20) @(negedge clk);
        chk("held_busy_end", 32'(bus.BUSY), 32'd0);
        bus.SELEC = 3'b000;
        repeat (3) @(negedge clk);
        chk("held_we_count", 32'(we_cnt - snap), 32'd1);
        chk("held_data", 32'(bus.RY_DATO_IN), 32'h0000_005E);

        // Second IN pulse while busy is ignored
        snap = we_cnt;
        start_read(8'h02, 3'd4, 8'hE1);
        @(negedge clk);
        bus.SELEC = 3'b000;
        @(negedge clk);
        chk("pulse_busy", 32'(bus.BUSY), 32'd1);
        bus.SELEC = SEL_IN;
        @(negedge clk);
        bus.SELEC = 3'b000;
        repeat (9) @(negedge clk);
        chk("pulse_we_count", 32'(we_cnt - snap), 32'd1);
        chk("pulse_busy_end", 32'(bus.BUSY), 32'd0);

        // Reset in REQ: no write, then a clean read
        snap = we_cnt;
        start_read(8'h77, 3'd6, 8'hBB);
        @(negedge clk);
        bus.SELEC = 3'b000;
        @(negedge clk);
        chk("mid_req_before", 32'(bus.RD_REQ), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_req_after",  32'(bus.RD_REQ), 32'd0);
        chk("mid_busy_after", 32'(bus.BUSY),   32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_no_we", 32'(we_cnt - snap), 32'd0);
        ideal_read("after_rst", 8'hC3, 3'd3, 8'h69);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/entradas_puerto.md
# entradas_puerto

Input-port reader for the UAZ micro: the read-side counterpart of the output stage. When the control unit issues the IN selector code, it drives an 8-bit port address onto the peripheral bus and runs a four-phase REQ/ACK handshake with the external device. It then writes the returned byte into the register file at index RY. It holds BUSY high so the control unit stalls for the duration, and reports a sticky timeout error.

## Interface
- TIMEOUT, 255: max cycles waited in each handshake phase; range 4..65535.
- SYNC_STAGES, 2: flops in the RD_ACK synchronizer; minimum 2.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- SELEC  in  3  control-unit selector; 3'b111 = IN.
- RX_DATO  in  8  port address, sampled at transaction start.
- RY  in  3  destination register index, sampled at transaction start.
- EXT_DATO  in  8  peripheral data; stable while RD_ACK high.
- RD_ACK  in  1  peripheral acknowledge; asynchronous to CLK.
- DIR_IN  out  8  port address on peripheral bus.
- RD_REQ  out  1  read request.
- RY_SEL  out  3  register-file write index.
- RY_DATO_IN  out  8  register-file write data.
- RY_WE  out  1  register-file write enable; one-cycle pulse.
- BUSY  out  1  transaction in progress.
- ERR  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, RELEASE, WRITE.
- ack_s is RD_ACK after SYNC_STAGES flops. The FSM uses only ack_s.
- Start condition: state IDLE, SELEC==3'b111, and the previous-cycle SELEC!=3'b111 (rising-edge detect on the IN code).
  - At start, latch RX_DATO into DIR_IN and RY into RY_SEL, clear ERR, clear the timer, and go to REQ.
  - A held IN code never retriggers.
- REQ: RD_REQ=1.
  - When ack_s==1: capture EXT_DATO into RY_DATO_IN, clear the timer, go to RELEASE.
- RELEASE: RD_REQ=0.
  - When ack_s==0: go to WRITE.
- WRITE: RY_WE=1 for exactly one cycle, then IDLE.
- Timeout: the 16-bit timer counts cycles spent in REQ or RELEASE.
  - Reaching TIMEOUT in REQ: RY_DATO_IN=8'hFF, ERR=1, go to RELEASE.
  - Reaching TIMEOUT in RELEASE: ERR=1, go to WRITE. Captured data is kept.
  - The timer saturates; it never wraps.
- BUSY is 1 in REQ, RELEASE and WRITE.
- SELEC=3'b111 while BUSY: ignored, not queued. The edge detector still tracks it, so a code held across the end of a transaction does not start a new one.
- Other SELEC codes (3'b101, 3'b110) have no effect on this block at any time.
- DIR_IN and RY_SEL hold their values after a transaction until the next start.

## Timing
- Reset values: DIR_IN=0, RD_REQ=0, RY_SEL=0, RY_DATO_IN=0, RY_WE=0, BUSY=0, ERR=0. Synchronizer flops=0, state=IDLE, timer=0, edge-detect register=0.
- Reset mid-transaction:
  - Next edge returns to IDLE with RD_REQ low.
  - No RY_WE pulse is issued.
  - The peripheral sees REQ drop and must release ACK.
- Latency, with SYNC_STAGES=2 and an ideal peripheral (ACK follows REQ in the same cycle). Cycle 0 is the cycle in which SELEC first reads 3'b111:
  - RD_REQ high in cycles 1–3.
  - Data captured at the edge ending cycle 3.
  - RY_WE high in cycle 7.
  - BUSY high in cycles 1–7.
- Each extra synchronizer stage adds 2 cycles: one per handshake phase.
- RD_REQ is driven directly from the state register; it is glitch-free.

## Structure
- Shared package io_pkg:
  - Selector constants SEL_DIR=3'b101, SEL_DATO=3'b110, SEL_IN=3'b111 (used by both the output and input stages).
  - State encoding for this FSM.
- Sub-module sync_ff, parameterised by stage count, for RD_ACK. It is reused for any future asynchronous peripheral inputs.

## Test plan
- Reset check: drive RST for 2 cycles with SELEC=3'b111 asserted. All outputs must read 0 and no transaction may start.
- Ideal read: RX_DATO=8'h3C, RY=3'd5, EXT_DATO=8'hA7; ACK follows REQ. Required:
  - DIR_IN=8'h3C from cycle 1.
  - Exactly one RY_WE pulse in cycle 7, with RY_SEL=5 and RY_DATO_IN=8'hA7.
  - ERR=0.
- Timeout with TIMEOUT=8, RD_ACK held 0: RY_WE pulses once with RY_DATO_IN=8'hFF and ERR=1. ERR clears at the next start.
- Stuck ACK: RD_ACK held 1 after the data phase. Must time out in RELEASE, write the captured byte, and set ERR=1.
- Held/retrigger: SELEC held at 3'b111 for 20 cycles produces exactly one transaction. A second pulse on SELEC during BUSY is ignored.
- Reset mid-operation: assert RST while in REQ. Required: next cycle RD_REQ=0 and BUSY=0, with no RY_WE pulse. A following normal read completes correctly.
